// File: rtl/reg_bank_storage_if.sv
// Write/clear request bus of the register-bank storage stage.
// The master issues writes and clear requests; the storage (slave) returns ack and clear status.
interface reg_bank_storage_if #(
    parameter int WIDTH = 32
);
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic             wr_ack;
    logic             busy;
    logic             done;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output clr_req,
        input  wr_ack,
        input  busy,
        input  done
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  clr_req,
        output wr_ack,
        output busy,
        output done
    );
endinterface

// File: rtl/reg_bank_storage.sv
// 16 x WIDTH register storage feeding the bank's 16:1 read mux.
// One registered write port with a one-cycle ack, plus a sequenced one-register-per-cycle clear engine.
module reg_bank_storage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_bank_storage_if.slave  bus,
    output logic [WIDTH-1:0]   q0,
    output logic [WIDTH-1:0]   q1,
    output logic [WIDTH-1:0]   q2,
    output logic [WIDTH-1:0]   q3,
    output logic [WIDTH-1:0]   q4,
    output logic [WIDTH-1:0]   q5,
    output logic [WIDTH-1:0]   q6,
    output logic [WIDTH-1:0]   q7,
    output logic [WIDTH-1:0]   q8,
    output logic [WIDTH-1:0]   q9,
    output logic [WIDTH-1:0]   q10,
    output logic [WIDTH-1:0]   q11,
    output logic [WIDTH-1:0]   q12,
    output logic [WIDTH-1:0]   q13,
    output logic [WIDTH-1:0]   q14,
    output logic [WIDTH-1:0]   q15
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       count;
    logic [WIDTH-1:0] regs [16];
    logic             wr_accept;
    logic             clear_step;
    logic             clear_last;
    logic             ack_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.clr_req) next_state = CLEAR;
            CLEAR:   if (count == 4'd15) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A clear request in IDLE takes priority and swallows any simultaneous write.
    always_comb begin
        wr_accept  = (state == IDLE) && !bus.clr_req && bus.wr_en;
        clear_step = (state == CLEAR);
        clear_last = (state == CLEAR) && (count == 4'd15);
        bus.busy   = (state == CLEAR);
        bus.wr_ack = ack_q;
        bus.done   = done_q;
    end

    // The counter sits at 0 in IDLE, so it is ready for register 0 on the first CLEAR cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clear_step) begin
            count <= count + 4'd1;
        end else begin
            count <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ack_q  <= wr_accept;
            done_q <= clear_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= CLEAR_VAL;
            end
        end else if (clear_step) begin
            regs[count] <= CLEAR_VAL;
        end else if (wr_accept) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign q0  = regs[0];
    assign q1  = regs[1];
    assign q2  = regs[2];
    assign q3  = regs[3];
    assign q4  = regs[4];
    assign q5  = regs[5];
    assign q6  = regs[6];
    assign q7  = regs[7];
    assign q8  = regs[8];
    assign q9  = regs[9];
    assign q10 = regs[10];
    assign q11 = regs[11];
    assign q12 = regs[12];
    assign q13 = regs[13];
    assign q14 = regs[14];
    assign q15 = regs[15];

endmodule
